// File: rtl/lsd_pkg.sv
// Shared types for the LSD segment line buffer: default frame geometry,
// the packed segment record stored in RAM, and the capture FSM states.
package lsd_pkg;

  localparam int LSD_H_FRAME = 640;
  localparam int LSD_V_FRAME = 480;
  localparam int LSD_BUFSIZE = 1024;
  localparam int LSD_HW      = $clog2(LSD_H_FRAME);
  localparam int LSD_VW      = $clog2(LSD_V_FRAME);
  localparam int LSD_AW      = $clog2(LSD_BUFSIZE);

  typedef struct packed {
    logic [LSD_HW-1:0] start_h;
    logic [LSD_VW-1:0] start_v;
    logic [LSD_HW-1:0] end_h;
    logic [LSD_VW-1:0] end_v;
  } lsd_seg_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    CAPTURE  = 2'd1,
    LOCKED   = 2'd2
  } lsd_buf_state_e;

  function automatic lsd_seg_t lsd_make_seg(input int sh, input int sv,
                                            input int eh, input int ev);
    lsd_seg_t s;
    s.start_h = LSD_HW'(sh);
    s.start_v = LSD_VW'(sv);
    s.end_h   = LSD_HW'(eh);
    s.end_v   = LSD_VW'(ev);
    return s;
  endfunction

endpackage

// File: rtl/lsd_line_ram.sv
// Simple dual-port segment RAM: one write port, one registered read port.
// No reset on the storage or read register so it maps onto block RAM.
module lsd_line_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 38,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lsd_line_buffer.sv
// Captures one frame of LSD segments, freezes it while the PS holds
// write-protect, and serves registered random-access reads to the PS.
module lsd_line_buffer
  import lsd_pkg::*;
#(
  parameter int H_FRAME     = 640,
  parameter int V_FRAME     = 480,
  parameter int LSD_BUFSIZE = 1024,
  localparam int HW = $clog2(H_FRAME),
  localparam int VW = $clog2(V_FRAME),
  localparam int AW = $clog2(LSD_BUFSIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_sof,
  input  logic          in_eof,
  input  logic          in_valid,
  input  logic [HW-1:0] in_start_h,
  input  logic [HW-1:0] in_end_h,
  input  logic [VW-1:0] in_start_v,
  input  logic [VW-1:0] in_end_v,
  input  logic          in_write_protect,
  input  logic [AW-1:0] in_raddr,
  output logic [AW-1:0] out_line_num,
  output logic [HW-1:0] out_start_h,
  output logic [HW-1:0] out_end_h,
  output logic [VW-1:0] out_start_v,
  output logic [VW-1:0] out_end_v,
  output logic          out_ready,
  output logic          out_overflow
);

  // Local layout follows the module parameters; matches lsd_seg_t at defaults.
  typedef struct packed {
    logic [HW-1:0] start_h;
    logic [VW-1:0] start_v;
    logic [HW-1:0] end_h;
    logic [VW-1:0] end_v;
  } seg_t;

  localparam int         SEG_W    = $bits(seg_t);
  localparam logic [AW:0] BUF_FULL = (AW+1)'(LSD_BUFSIZE);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  lsd_buf_state_e state_q, state_d;

  // Pointer and committed count carry one extra bit so a full buffer is representable.
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   line_num_q;
  logic          frame_ovf_q;
  logic          overflow_q;
  logic          rd_valid_q;

  logic          buf_full;
  logic          frame_start;
  logic          wr_en;
  logic          drop;
  logic          commit;
  logic [AW-1:0] wr_addr;
  seg_t          wr_seg;
  seg_t          rd_seg;
  logic [SEG_W-1:0] rd_word;

  assign buf_full = (wr_ptr_q == BUF_FULL);
  assign wr_addr  = frame_start ? '0 : wr_ptr_q[AW-1:0];

  always_comb begin
    wr_seg         = '0;
    wr_seg.start_h = in_start_h;
    wr_seg.start_v = in_start_v;
    wr_seg.end_h   = in_end_h;
    wr_seg.end_v   = in_end_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SOF;
    end else begin
      state_q <= state_d;
    end
  end

  // A restart sof takes priority over a same-cycle eof in CAPTURE.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    wr_en       = 1'b0;
    drop        = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      WAIT_SOF: begin
        if (in_sof) begin
          frame_start = 1'b1;
          wr_en       = in_valid;
          state_d     = CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_sof) begin
          frame_start = 1'b1;
          wr_en       = in_valid;
        end else begin
          wr_en = in_valid && !buf_full;
          drop  = in_valid && buf_full;
          if (in_eof) begin
            commit  = 1'b1;
            state_d = in_write_protect ? LOCKED : WAIT_SOF;
          end
        end
      end
      LOCKED: begin
        if (!in_write_protect) begin
          state_d = WAIT_SOF;
        end
      end
      default: begin
        state_d = WAIT_SOF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      frame_ovf_q <= 1'b0;
      line_num_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (frame_start) begin
        wr_ptr_q    <= (AW+1)'(in_valid);
        frame_ovf_q <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        end
        if (drop) begin
          frame_ovf_q <= 1'b1;
        end
      end
      // Commit includes a segment written on the eof cycle itself.
      if (commit) begin
        line_num_q <= wr_ptr_q + (wr_en ? PTR_ONE : '0);
        overflow_q <= frame_ovf_q | drop;
      end
    end
  end

  lsd_line_ram #(
    .DEPTH (LSD_BUFSIZE),
    .WIDTH (SEG_W)
  ) u_ram (
    .clk   (clk),
    .wr_en (wr_en),
    .waddr (wr_addr),
    .wdata (wr_seg),
    .raddr (in_raddr),
    .rdata (rd_word)
  );

  // Range check is registered alongside the RAM read so both align at the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= ({1'b0, in_raddr} < line_num_q);
    end
  end

  assign rd_seg       = rd_valid_q ? seg_t'(rd_word) : '0;
  assign out_start_h  = rd_seg.start_h;
  assign out_start_v  = rd_seg.start_v;
  assign out_end_h    = rd_seg.end_h;
  assign out_end_v    = rd_seg.end_v;
  assign out_line_num = line_num_q[AW-1:0];
  assign out_overflow = overflow_q;
  assign out_ready    = (state_q == LOCKED);

endmodule
